// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO: synchronises the Gray write
// pointer into the read clock domain, advances the read pointer on accepted
// reads, and produces registered empty / almost-empty / fill-level flags.
module fifo_rd_ctrl #(
    parameter int DEEPWID = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_en,
    input  logic [DEEPWID:0]   wr_addr_g,
    input  logic [DEEPWID-1:0] cfg_almost_empty,
    output logic               rd_fire,
    output logic [DEEPWID-1:0] mem_raddr,
    output logic [DEEPWID:0]   rd_addr_b,
    output logic [DEEPWID:0]   rd_addr_g,
    output logic               empty,
    output logic               almost_empty,
    output logic [DEEPWID:0]   fifo_num,
    output logic               underflow
);

    logic [DEEPWID:0] wr_addr_g_r;
    logic [DEEPWID:0] wr_addr_g_rr;
    logic [DEEPWID:0] wr_addr_b_rr;
    logic [DEEPWID:0] rd_b_next;
    logic [DEEPWID:0] rd_g_next;
    logic [DEEPWID:0] fill_next;

    // Two-flop synchroniser for the write-domain Gray pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr_g_r  <= '0;
            wr_addr_g_rr <= '0;
        end else begin
            wr_addr_g_r  <= wr_addr_g;
            wr_addr_g_rr <= wr_addr_g_r;
        end
    end

    // Gray to binary: each bit is the XOR of itself and all higher Gray bits.
    always_comb begin
        wr_addr_b_rr = '0;
        for (int unsigned i = 0; i <= DEEPWID; i++) begin
            wr_addr_b_rr[i] = ^(wr_addr_g_rr >> i);
        end
    end

    assign rd_fire   = rd_en & ~empty;
    assign rd_b_next = rd_addr_b + {{DEEPWID{1'b0}}, rd_fire};
    assign rd_g_next = rd_b_next ^ (rd_b_next >> 1);
    assign fill_next = wr_addr_b_rr - rd_b_next;
    assign mem_raddr = rd_addr_b[DEEPWID-1:0];

    // Pointer and flag registers; flags look ahead at the post-read pointer
    // so the edge that consumes the last entry also raises empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_b    <= '0;
            rd_addr_g    <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            fifo_num     <= '0;
            underflow    <= 1'b0;
        end else begin
            rd_addr_b    <= rd_b_next;
            rd_addr_g    <= rd_g_next;
            empty        <= (rd_g_next == wr_addr_g_rr);
            almost_empty <= (fill_next <= {1'b0, cfg_almost_empty});
            fifo_num     <= fill_next;
            underflow    <= rd_en & empty;
        end
    end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed self-checking bench for fifo_rd_ctrl (DEEPWID=3, cfg_almost_empty=1).
module tb_fifo_rd_ctrl;

    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          clk_run = 1'b0;
    logic          rst_n = 1'b1;
    logic          rd_en = 1'b0;
    logic [DW:0]   wr_addr_g = '0;
    logic [DW-1:0] cfg_almost_empty = 3'd1;
    logic          rd_fire;
    logic [DW-1:0] mem_raddr;
    logic [DW:0]   rd_addr_b;
    logic [DW:0]   rd_addr_g;
    logic          empty;
    logic          almost_empty;
    logic [DW:0]   fifo_num;
    logic          underflow;

    int total = 0;
    int bad   = 0;

    fifo_rd_ctrl #(.DEEPWID(DW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rd_en            (rd_en),
        .wr_addr_g        (wr_addr_g),
        .cfg_almost_empty (cfg_almost_empty),
        .rd_fire          (rd_fire),
        .mem_raddr        (mem_raddr),
        .rd_addr_b        (rd_addr_b),
        .rd_addr_g        (rd_addr_g),
        .empty            (empty),
        .almost_empty     (almost_empty),
        .fifo_num         (fifo_num),
        .underflow        (underflow)
    );

    always #5 clk = clk_run ? ~clk : clk;

    typedef struct {
        logic        rd_en;
        logic [3:0]  wr;
        logic        fire;
        logic        empty;
        logic        ae;
        logic [3:0]  num;
        logic [3:0]  rb;
        logic [3:0]  rg;
        logic        uf;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " empty"}, {31'd0, empty}, 32'd1);
        chk({tag, " almost_empty"}, {31'd0, almost_empty}, 32'd1);
        chk({tag, " fifo_num"}, {28'd0, fifo_num}, 32'd0);
        chk({tag, " rd_addr_b"}, {28'd0, rd_addr_b}, 32'd0);
        chk({tag, " rd_addr_g"}, {28'd0, rd_addr_g}, 32'd0);
        chk({tag, " underflow"}, {31'd0, underflow}, 32'd0);
        chk({tag, " mem_raddr"}, {29'd0, mem_raddr}, 32'd0);
    endtask

    logic [3:0] wb;
    logic [3:0] gexp;
    logic [3:0] prev_g;
    logic [3:0] dn;

    initial begin
        //            rd  wr       fire e     ae    num    rb     rg       uf
        tbl[0]  = '{1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'b0000, 1'b0};
        tbl[1]  = '{1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'b0000, 1'b0};
        tbl[2]  = '{1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 4'b0000, 1'b0};
        tbl[3]  = '{1'b1, 4'b0001, 1'b1, 1'b1, 1'b1, 4'd0, 4'd1, 4'b0001, 1'b0};
        tbl[4]  = '{1'b1, 4'b0001, 1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 4'b0001, 1'b1};
        tbl[5]  = '{1'b0, 4'b0001, 1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 4'b0001, 1'b0};
        tbl[6]  = '{1'b0, 4'b0111, 1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 4'b0001, 1'b0};
        tbl[7]  = '{1'b0, 4'b0111, 1'b0, 1'b1, 1'b1, 4'd0, 4'd1, 4'b0001, 1'b0};
        tbl[8]  = '{1'b0, 4'b0111, 1'b0, 1'b0, 1'b0, 4'd4, 4'd1, 4'b0001, 1'b0};
        tbl[9]  = '{1'b1, 4'b0111, 1'b1, 1'b0, 1'b0, 4'd3, 4'd2, 4'b0011, 1'b0};
        tbl[10] = '{1'b1, 4'b0111, 1'b1, 1'b0, 1'b0, 4'd2, 4'd3, 4'b0010, 1'b0};
        tbl[11] = '{1'b1, 4'b0111, 1'b1, 1'b0, 1'b1, 4'd1, 4'd4, 4'b0110, 1'b0};
        tbl[12] = '{1'b1, 4'b0111, 1'b1, 1'b1, 1'b1, 4'd0, 4'd5, 4'b0111, 1'b0};
        tbl[13] = '{1'b0, 4'b0111, 1'b0, 1'b1, 1'b1, 4'd0, 4'd5, 4'b0111, 1'b0};

        // Asynchronous reset with the clock stopped.
        #2;
        wr_addr_g = 4'b0110;
        rst_n = 1'b0;
        #2;
        chk_reset_vals("async_reset");
        chk("async_reset rd_fire", {31'd0, rd_fire}, 32'd0);

        wr_addr_g = 4'b0000;
        clk_run = 1'b1;
        edge1();
        edge1();
        rst_n = 1'b1;

        // Cycle-by-cycle vectors: fill detect latency, last-entry read,
        // underflow pulse, drain with almost-empty threshold.
        for (int i = 0; i < 14; i++) begin
            rd_en = tbl[i].rd_en;
            wr_addr_g = tbl[i].wr;
            #1;
            chk($sformatf("vec%0d rd_fire", i), {31'd0, rd_fire}, {31'd0, tbl[i].fire});
            edge1();
            chk($sformatf("vec%0d empty", i), {31'd0, empty}, {31'd0, tbl[i].empty});
            chk($sformatf("vec%0d almost_empty", i), {31'd0, almost_empty}, {31'd0, tbl[i].ae});
            chk($sformatf("vec%0d fifo_num", i), {28'd0, fifo_num}, {28'd0, tbl[i].num});
            chk($sformatf("vec%0d rd_addr_b", i), {28'd0, rd_addr_b}, {28'd0, tbl[i].rb});
            chk($sformatf("vec%0d rd_addr_g", i), {28'd0, rd_addr_g}, {28'd0, tbl[i].rg});
            chk($sformatf("vec%0d mem_raddr", i), {29'd0, mem_raddr}, {29'd0, tbl[i].rb[2:0]});
            chk($sformatf("vec%0d underflow", i), {31'd0, underflow}, {31'd0, tbl[i].uf});
        end
        rd_en = 1'b0;

        // Drain of four entries from reset.
        rst_n = 1'b0;
        wr_addr_g = 4'b0110;
        edge1();
        rst_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            edge1();
            chk($sformatf("drain_fill edge%0d empty", e), {31'd0, empty}, (e == 3) ? 32'd0 : 32'd1);
            chk($sformatf("drain_fill edge%0d fifo_num", e), {28'd0, fifo_num}, (e == 3) ? 32'd4 : 32'd0);
        end
        chk("drain_fill almost_empty", {31'd0, almost_empty}, 32'd0);
        rd_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("drain%0d rd_fire", k), {31'd0, rd_fire}, 32'd1);
            chk($sformatf("drain%0d mem_raddr", k), {29'd0, mem_raddr}, k);
            edge1();
            dn = 4'(3 - k);
            chk($sformatf("drain%0d fifo_num", k), {28'd0, fifo_num}, {28'd0, dn});
            chk($sformatf("drain%0d almost_empty", k), {31'd0, almost_empty}, (k >= 2) ? 32'd1 : 32'd0);
            chk($sformatf("drain%0d empty", k), {31'd0, empty}, (k == 3) ? 32'd1 : 32'd0);
        end
        rd_en = 1'b0;

        // Reset in the middle of a drain, then recovery timing.
        rst_n = 1'b0;
        edge1();
        rst_n = 1'b1;
        repeat (3) edge1();
        chk("middrain_pre fifo_num", {28'd0, fifo_num}, 32'd4);
        rd_en = 1'b1;
        edge1();
        edge1();
        chk("middrain_two_reads fifo_num", {28'd0, fifo_num}, 32'd2);
        chk("middrain_two_reads rd_addr_b", {28'd0, rd_addr_b}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("middrain_reset");
        chk("middrain_reset rd_fire", {31'd0, rd_fire}, 32'd0);
        edge1();
        rd_en = 1'b0;
        rst_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            edge1();
            chk($sformatf("recover edge%0d empty", e), {31'd0, empty}, (e == 3) ? 32'd0 : 32'd1);
            chk($sformatf("recover edge%0d fifo_num", e), {28'd0, fifo_num}, (e == 3) ? 32'd4 : 32'd0);
            chk($sformatf("recover edge%0d rd_addr_b", e), {28'd0, rd_addr_b}, 32'd0);
        end

        // Sixteen single-entry write/read rounds across the pointer wrap.
        rst_n = 1'b0;
        wr_addr_g = 4'b0000;
        edge1();
        rst_n = 1'b1;
        prev_g = 4'b0000;
        for (int k = 1; k <= 16; k++) begin
            wb = 4'(k);
            wr_addr_g = wb ^ (wb >> 1);
            repeat (3) edge1();
            chk($sformatf("wrap%0d pre empty", k), {31'd0, empty}, 32'd0);
            chk($sformatf("wrap%0d pre fifo_num", k), {28'd0, fifo_num}, 32'd1);
            chk($sformatf("wrap%0d pre underflow", k), {31'd0, underflow}, 32'd0);
            rd_en = 1'b1;
            #1;
            chk($sformatf("wrap%0d rd_fire", k), {31'd0, rd_fire}, 32'd1);
            edge1();
            rd_en = 1'b0;
            gexp = wb ^ (wb >> 1);
            chk($sformatf("wrap%0d rd_addr_b", k), {28'd0, rd_addr_b}, {28'd0, wb});
            chk($sformatf("wrap%0d rd_addr_g", k), {28'd0, rd_addr_g}, {28'd0, gexp});
            chk($sformatf("wrap%0d empty", k), {31'd0, empty}, 32'd1);
            chk($sformatf("wrap%0d gray_step", k), $countones(rd_addr_g ^ prev_g), 32'd1);
            prev_g = rd_addr_g;
        end
        chk("wrap final rd_addr_b", {28'd0, rd_addr_b}, 32'd0);
        chk("wrap final underflow", {31'd0, underflow}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
